// File: rtl/axis_dac_streamer.sv
// AXI-Stream to parallel DAC streamer: buffers samples in a FIFO and plays them out at a programmable rate.
// Define AXIS_DAC_STREAMER_SATURATE_EN to clamp the offset arithmetic instead of wrapping it.
module axis_dac_streamer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [DATA_W-1:0]           S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    input  logic [DATA_W-1:0]           Offset,
    input  logic                        Invert,
    input  logic [DIV_W-1:0]            Rate_Div,
    input  logic                        Underrun_Clr,
    output logic [DATA_W-1:0]           DAC_Data,
    output logic                        DAC_CLK,
    output logic                        Underrun,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_Level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] HALF_LEVEL = LW'(FIFO_DEPTH / 2);
    localparam logic [AW:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STARVED = 2'd2;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_level;
    logic              r_readyEn;
    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dacData;
    logic              r_dacClk;
    logic              r_underrun;

    logic              w_full;
    logic              w_empty;
    logic              w_halfFull;
    logic              w_push;
    logic              w_pop;
    logic              w_tick;
    logic              w_starve;
    logic [DIV_W-1:0]  w_rate;
    logic [DIV_W-1:0]  w_half;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_sample;

    // A divider of 0 would make every cycle a tick, so it is promoted to 1.
    assign w_rate     = (Rate_Div < DIV_W'(2)) ? DIV_W'(1) : Rate_Div;
    assign w_half     = w_rate >> 1;
    assign w_full     = (r_level == FULL_LEVEL);
    assign w_empty    = (r_level == '0);
    assign w_halfFull = (r_level >= HALF_LEVEL);
    assign w_push     = S_AXIS_tvalid && S_AXIS_tready;
    assign w_tick     = (r_state != ST_IDLE) && (r_cnt >= w_rate);
    assign w_pop      = (r_state == ST_RUN) && w_tick && !w_empty;
    assign w_starve   = (r_state == ST_RUN) && w_tick && w_empty;
    assign w_head     = r_mem[r_rdPtr];

`ifdef AXIS_DAC_STREAMER_SATURATE_EN
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum    = {1'b0, Offset} + {1'b0, w_head};
    assign w_diff   = {1'b0, Offset} - {1'b0, w_head};
    assign w_sample = Invert ? (w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0])
                             : (w_sum[DATA_W]  ? '1 : w_sum[DATA_W-1:0]);
`else
    assign w_sample = Invert ? (Offset - w_head) : (Offset + w_head);
`endif

    assign S_AXIS_tready = r_readyEn && !w_full;
    assign Fifo_Level    = r_level;
    assign DAC_Data      = r_dacData;
    assign DAC_CLK       = r_dacClk;
    assign Underrun      = r_underrun;

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= S_AXIS_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_level   <= '0;
            r_readyEn <= 1'b0;
        end else begin
            r_readyEn <= 1'b1;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // The strobe falls with each tick and rises mid-period, so data is stable before the rising edge.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dacData <= '0;
            r_dacClk  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= '0;
                    r_dacData <= '0;
                    r_dacClk  <= 1'b0;
                    if (w_halfFull) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN, ST_STARVED: begin
                    if (w_tick) begin
                        r_cnt    <= '0;
                        r_dacClk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                        if (r_cnt == w_half) begin
                            r_dacClk <= 1'b1;
                        end
                    end
                    if (w_pop) begin
                        r_dacData <= w_sample;
                    end
                    if (w_starve) begin
                        r_state <= ST_STARVED;
                    end else if ((r_state == ST_STARVED) && w_halfFull) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_underrun <= 1'b0;
        end else if (w_starve) begin
            r_underrun <= 1'b1;
        end else if (Underrun_Clr) begin
            r_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_dac_streamer.sv
// Self-checking bench for axis_dac_streamer: directed scenarios plus random traffic against a queue-based model.
// Honours AXIS_DAC_STREAMER_SATURATE_EN when computing expected DAC words.
module tb_axis_dac_streamer;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int MAXV       = (1 << DATA_W) - 1;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [DATA_W-1:0] S_AXIS_tdata = '0;
    logic              S_AXIS_tvalid = 1'b0;
    logic              S_AXIS_tready;
    logic [DATA_W-1:0] Offset = '0;
    logic              Invert = 1'b0;
    logic [DIV_W-1:0]  Rate_Div = '0;
    logic              Underrun_Clr = 1'b0;
    logic [DATA_W-1:0] DAC_Data;
    logic              DAC_CLK;
    logic              Underrun;
    logic [$clog2(FIFO_DEPTH):0] Fifo_Level;

    int nTests = 0;
    int nFail  = 0;
    bit checkEn = 1'b0;

    always #5 aclk = ~aclk;

    axis_dac_streamer #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .Offset(Offset), .Invert(Invert), .Rate_Div(Rate_Div), .Underrun_Clr(Underrun_Clr),
        .DAC_Data(DAC_Data), .DAC_CLK(DAC_CLK), .Underrun(Underrun), .Fifo_Level(Fifo_Level)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        nTests++;
        nFail++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic int xform(input int off, input int s, input bit inv);
`ifdef AXIS_DAC_STREAMER_SATURATE_EN
        if (inv) return (off >= s) ? off - s : 0;
        return (off + s > MAXV) ? MAXV : off + s;
`else
        if (inv) return (off - s) & MAXV;
        return (off + s) & MAXV;
`endif
    endfunction

    // Behavioural model: a sample queue plus "started/starved" flags and a cycles-since-tick phase.
    int mq[$];
    bit mStarted = 0, mStarved = 0, mReadyEn = 0, mClk = 0, mUnder = 0;
    int mPhase = 0, mData = 0;

    always @(posedge aclk) begin : modelStep
        int r, lvl;
        bit tick, push, pop, starve;
        if (!aresetn) begin
            mq.delete();
            mStarted = 0; mStarved = 0; mReadyEn = 0;
            mPhase = 0; mData = 0; mClk = 0; mUnder = 0;
        end else begin
            lvl    = mq.size();
            r      = (Rate_Div < 2) ? 1 : int'(Rate_Div);
            push   = S_AXIS_tvalid && mReadyEn && (lvl < FIFO_DEPTH);
            tick   = mStarted && (mPhase >= r);
            pop    = tick && !mStarved && (lvl > 0);
            starve = tick && !mStarved && (lvl == 0);
            if (pop) mData = xform(int'(Offset), mq.pop_front(), Invert);
            if (push) mq.push_back(int'(S_AXIS_tdata));
            if (!mStarted) begin
                mPhase = 0; mClk = 0; mData = 0;
            end else if (tick) begin
                mPhase = 0; mClk = 0;
            end else begin
                if (mPhase == r / 2) mClk = 1;
                mPhase++;
            end
            if (starve) mUnder = 1;
            else if (Underrun_Clr) mUnder = 0;
            if (!mStarted) mStarted = (lvl >= FIFO_DEPTH / 2);
            else if (mStarved) mStarved = (lvl < FIFO_DEPTH / 2);
            else if (starve) mStarved = 1;
            mReadyEn = 1;
        end
    end

    always @(negedge aclk) begin
        if (checkEn) begin
            checkOutput("model.tready", 32'(S_AXIS_tready), 32'(mReadyEn && (mq.size() < FIFO_DEPTH)));
            checkOutput("model.level", 32'(Fifo_Level), 32'(mq.size()));
            checkOutput("model.dacData", 32'(DAC_Data), 32'(mData));
            checkOutput("model.dacClk", 32'(DAC_CLK), 32'(mClk));
            checkOutput("model.underrun", 32'(Underrun), 32'(mUnder));
        end
    end

    task automatic tickWait(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic doReset();
        aresetn = 1'b0;
        S_AXIS_tvalid = 1'b0;
        Underrun_Clr = 1'b0;
        tickWait(2);
        aresetn = 1'b1;
        tickWait(1);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] d);
        bit accepted = 0;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata = d;
        for (int w = 0; w < 50 && !accepted; w++) begin
            accepted = S_AXIS_tready;
            tickWait(1);
        end
        S_AXIS_tvalid = 1'b0;
        if (!accepted) reportTimeout("pushSample");
    endtask

    initial begin
        int updK[$];
        int updV[$];
        bit clkHist[48];
        logic [DATA_W-1:0] prevData;
        bit found;
        int falls[$];
        bit prevClk;
        int pv;

        // Reset state
        aresetn = 1'b0;
        tickWait(1);
        checkEn = 1'b1;
        tickWait(1);
        checkOutput("reset.level", 32'(Fifo_Level), 0);
        checkOutput("reset.tready", 32'(S_AXIS_tready), 0);
        checkOutput("reset.dacData", 32'(DAC_Data), 0);
        checkOutput("reset.dacClk", 32'(DAC_CLK), 0);
        checkOutput("reset.underrun", 32'(Underrun), 0);
        aresetn = 1'b1;
        tickWait(1);
        checkOutput("reset.readyRise", 32'(S_AXIS_tready), 1);

        // Eight samples, inverted around 0x80, four-cycle period
        Rate_Div = 16'd3; Offset = 8'h80; Invert = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h10 + i));
        checkOutput("play.levelAfterFill", 32'(Fifo_Level), 8);
        prevData = DAC_Data;
        for (int k = 0; k < 48; k++) begin
            tickWait(1);
            clkHist[k] = DAC_CLK;
            if (DAC_Data != prevData) begin
                updK.push_back(k);
                updV.push_back(int'(DAC_Data));
            end
            prevData = DAC_Data;
        end
        checkOutput("play.updateCount", 32'(updK.size()), 8);
        for (int i = 0; i < updK.size() && i < 8; i++) begin
            checkOutput("play.value", 32'(updV[i]), 32'(8'h70 - i));
            if (i > 0) checkOutput("play.period", 32'(updK[i] - updK[i-1]), 4);
            if (updK[i] + 2 < 48) begin
                checkOutput("play.clkLowAtUpdate", 32'(clkHist[updK[i]]), 0);
                checkOutput("play.clkLowAfter1", 32'(clkHist[updK[i] + 1]), 0);
                checkOutput("play.clkRiseAfter2", 32'(clkHist[updK[i] + 2]), 1);
            end
        end
        checkOutput("starve.underrun", 32'(Underrun), 1);
        checkOutput("starve.holdData", 32'(DAC_Data), 32'h69);

        // Refill from starvation, then clear the sticky flag
        for (int i = 0; i < 8; i++) applyStimulus(8'($urandom_range(0, MAXV)));
        checkOutput("refill.underrunStillSet", 32'(Underrun), 1);
        Underrun_Clr = 1'b1;
        tickWait(1);
        Underrun_Clr = 1'b0;
        checkOutput("refill.underrunCleared", 32'(Underrun), 0);
        tickWait(40);

        // Overfill without ticks
        doReset();
        Rate_Div = 16'hFFFF;
        S_AXIS_tvalid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            S_AXIS_tdata = 8'($urandom_range(0, MAXV));
            tickWait(1);
        end
        checkOutput("full.level", 32'(Fifo_Level), 16);
        checkOutput("full.tready", 32'(S_AXIS_tready), 0);
        tickWait(4);
        checkOutput("full.levelHeld", 32'(Fifo_Level), 16);
        S_AXIS_tvalid = 1'b0;

        // Offset arithmetic boundaries
        doReset();
        Rate_Div = 16'd1; Offset = 8'hF0; Invert = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'h20);
        found = 0;
        for (int w = 0; w < 20 && !found; w++) begin
            tickWait(1);
            found = (DAC_Data != 0);
        end
        if (!found) reportTimeout("arith.firstUpdate");
`ifdef AXIS_DAC_STREAMER_SATURATE_EN
        checkOutput("arith.addClamp", 32'(DAC_Data), 32'hFF);
`else
        checkOutput("arith.addWrap", 32'(DAC_Data), 32'h10);
`endif
        Offset = 8'h05; Invert = 1'b1;
        tickWait(4);
`ifdef AXIS_DAC_STREAMER_SATURATE_EN
        checkOutput("arith.subClamp", 32'(DAC_Data), 32'h00);
`else
        checkOutput("arith.subWrap", 32'(DAC_Data), 32'hE5);
`endif
        tickWait(20);

        // Mid-stream reset with six samples buffered
        doReset();
        Rate_Div = 16'd5; Offset = 8'h11; Invert = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'($urandom_range(0, MAXV)));
        found = 0;
        for (int w = 0; w < 60 && !found; w++) begin
            found = (Fifo_Level == 6);
            if (!found) tickWait(1);
        end
        if (!found) reportTimeout("midReset.level6");
        aresetn = 1'b0;
        tickWait(1);
        checkOutput("midReset.level", 32'(Fifo_Level), 0);
        checkOutput("midReset.dacData", 32'(DAC_Data), 0);
        checkOutput("midReset.dacClk", 32'(DAC_CLK), 0);
        aresetn = 1'b1;
        tickWait(1);

        // Shrinking the divider mid-period
        Rate_Div = 16'd9;
        for (int i = 0; i < 16; i++) applyStimulus(8'($urandom_range(0, MAXV)));
        found = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            found = mStarted && (mPhase == 6);
            if (!found) tickWait(1);
        end
        if (!found) reportTimeout("rateChange.phase6");
        checkOutput("rateChange.clkHigh", 32'(DAC_CLK), 1);
        Rate_Div = 16'd2;
        prevClk = DAC_CLK;
        for (int k = 1; k <= 8; k++) begin
            tickWait(1);
            if (prevClk && !DAC_CLK) falls.push_back(k);
            prevClk = DAC_CLK;
        end
        checkOutput("rateChange.fallCount", 32'(falls.size()), 3);
        if (falls.size() >= 3) begin
            checkOutput("rateChange.firstTick", 32'(falls[0]), 1);
            checkOutput("rateChange.period1", 32'(falls[1] - falls[0]), 3);
            checkOutput("rateChange.period2", 32'(falls[2] - falls[1]), 3);
        end

        // Random traffic
        doReset();
        pv = 50;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) pv = (c % 600 == 0) ? 20 : ((c % 400 == 0) ? 90 : 50);
            if (c % 50 == 0) begin
                Offset   = 8'($urandom_range(0, MAXV));
                Invert   = 1'($urandom_range(0, 1));
                Rate_Div = 16'($urandom_range(0, 6));
            end
            S_AXIS_tvalid = ($urandom_range(0, 99) < pv);
            S_AXIS_tdata  = 8'($urandom_range(0, MAXV));
            Underrun_Clr  = ($urandom_range(0, 19) == 0);
            aresetn       = ($urandom_range(0, 299) != 0);
            tickWait(1);
        end
        aresetn = 1'b1;
        S_AXIS_tvalid = 1'b0;
        Underrun_Clr = 1'b0;
        tickWait(2);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/axis_dac_streamer.md
AXIS_DAC_STREAMER -- requirements
Module: axis_dac_streamer

Interface
REQ-001 Parameter DATA_W, default 8, sample and DAC word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, sample buffer depth; power of two, 4 or greater.
REQ-003 Parameter DIV_W, default 16, width of the Rate_Div port.
REQ-004 aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 aresetn  in  1  reset; synchronous, active-low.
REQ-006 S_AXIS_tdata  in  DATA_W  input sample.
REQ-007 S_AXIS_tvalid  in  1  sample valid.
REQ-008 S_AXIS_tready  out  1  block can accept a sample.
REQ-009 Offset  in  DATA_W  additive offset applied to every sample.
REQ-010 Invert  in  1  1: output = Offset - sample; 0: output = Offset + sample.
REQ-011 Rate_Div  in  DIV_W  output sample period minus 1, in aclk cycles; values 0 and 1 are both treated as 1.
REQ-012 Underrun_Clr  in  1  single-cycle pulse that clears Underrun.
REQ-013 DAC_Data  out  DATA_W  registered DAC word.
REQ-014 DAC_CLK  out  1  registered DAC strobe; not a gated clock.
REQ-015 Underrun  out  1  sticky flag: a sample tick found the FIFO empty.
REQ-016 Fifo_Level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 S_AXIS_tready SHALL equal !full; a push occurs on any cycle where tvalid and tready are both 1.
REQ-018 A push and a pop in the same cycle SHALL leave Fifo_Level unchanged, and push at full SHALL be impossible.
REQ-019 Period counter cnt SHALL count 0..R, where R is the effective Rate_Div; tick is asserted when cnt >= R, after which cnt returns to 0. The >= comparison keeps the counter safe when Rate_Div shrinks mid-period.
REQ-020 The state machine SHALL have three states: IDLE, RUN and STARVED. Reset enters IDLE.
REQ-021 IDLE SHALL move to RUN when Fifo_Level >= FIFO_DEPTH/2. While in IDLE, cnt is held at 0, DAC_Data = 0 and DAC_CLK = 0.
REQ-022 In RUN, a tick with the FIFO non-empty SHALL pop one sample. DAC_Data SHALL present the transformed sample on the cycle after the tick, giving a latency of 1 cycle from pop.
REQ-023 In RUN, a tick with the FIFO empty SHALL enter STARVED, hold DAC_Data and set Underrun.
REQ-024 STARVED SHALL hold DAC_Data and keep DAC_CLK toggling. It SHALL return to RUN when Fifo_Level >= FIFO_DEPTH/2, with the first pop on the next tick.
REQ-025 DAC_CLK SHALL go 0 on the cycle DAC_Data updates and go 1 when cnt == R>>1. This gives the DAC a full low-to-high setup window.
REQ-026 Arithmetic SHALL be unsigned DATA_W-bit and SHALL wrap modulo 2^DATA_W, unless SATURATE_EN is defined.
REQ-027 Offset, Invert and Rate_Div SHALL be sampled live with no shadowing; changes take effect from the next tick.
REQ-028 If Underrun_Clr is asserted in the same cycle as a new underrun event, set SHALL win.

Reset
REQ-029 While aresetn = 0 at a rising edge, the block SHALL reset as follows: FIFO emptied (contents discarded), Fifo_Level = 0, S_AXIS_tready = 0, state = IDLE, cnt = 0, DAC_Data = 0, DAC_CLK = 0, Underrun = 0.
REQ-030 S_AXIS_tready SHALL rise on the first cycle after aresetn is sampled high.
REQ-031 A reset asserted mid-stream SHALL take effect at the next edge without completing the pending pop or DAC update.

Configuration
REQ-032 Macro AXIS_DAC_STREAMER_SATURATE_EN behaviour:
- Defined: Offset + sample clamps to 2^DATA_W-1, and Offset - sample clamps to 0.
- Undefined: both results wrap modulo 2^DATA_W, and no saturation logic is synthesised.

Verification
REQ-033 Reset, then push 8 samples 0x10..0x17 with Rate_Div = 3, Offset = 0x80, Invert = 1. Expected: RUN entered after the 8th push; DAC_Data sequence 0x70, 0x6F, ... 0x69; each value lasts 4 cycles; DAC_CLK rises 2 cycles after each update.
REQ-034 Hold tvalid = 1 with no ticks (IDLE, prefill). Expected: Fifo_Level reaches 16, tready = 0, and no further pushes occur.
REQ-035 Stop the input while in RUN. Expected: after the last sample, the next tick sets Underrun = 1, state = STARVED, and DAC_Data holds its last value. Refill 8 samples -> RUN. Pulse Underrun_Clr -> Underrun = 0.
REQ-036 Offset = 0xF0, Invert = 0, sample = 0x20. Expected: DAC_Data = 0x10 without the macro, 0xFF with it. Offset = 0x05, Invert = 1, sample = 0x20: expected 0xE5 without the macro, 0x00 with it.
REQ-037 Drop aresetn for 1 cycle with the FIFO holding 6 samples in RUN. Expected next cycle: Fifo_Level = 0, DAC_Data = 0, DAC_CLK = 0, state = IDLE.
REQ-038 Change Rate_Div from 9 to 2 while cnt = 6. Expected: a tick on the next cycle, then a 3-cycle period thereafter.
